// File: rtl/mem_arb_if.sv
// Bus bundle between the two requesters, the arbiter and main memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arb_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) ();
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              d_req;
   logic              d_wr;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              i_done;
   logic              d_done;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic              mem_req;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_done;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_done, mem_rdata,
      output i_done, d_done, rdata, busy, mem_req, mem_wr, mem_addr, mem_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_done, mem_rdata,
      input  i_done, d_done, rdata, busy, mem_req, mem_wr, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arb.sv
// Fetch/data arbiter for single-ported, variable-latency main memory.
// Data wins ties until fetch has waited STARVE_LIM consecutive data grants.
module mem_arb #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int STARVE_LIM = 4
) (
   input logic      clk,
   input logic      rst,
   mem_arb_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_e;

   localparam logic [3:0] LIM = 4'(STARVE_LIM);

   state_e            state_q, state_d;
   logic [3:0]        starve_q, starve_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              i_done_q, i_done_d;
   logic              d_done_q, d_done_d;
   logic              busy_q, busy_d;

   // Arbitration, transaction tracking and output staging.
   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      mem_req_d   = mem_req_q;
      mem_wr_d    = mem_wr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      i_done_d    = 1'b0;
      d_done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.d_req && !(bus.i_req && (starve_q == LIM))) begin
               state_d     = BUSY_D;
               mem_req_d   = 1'b1;
               mem_wr_d    = bus.d_wr;
               mem_addr_d  = bus.d_addr;
               mem_wdata_d = bus.d_wdata;
               if (!bus.i_req) begin
                  starve_d = 4'd0;
               end else if (starve_q >= LIM) begin
                  starve_d = LIM;
               end else begin
                  starve_d = starve_q + 4'd1;
               end
            end else if (bus.i_req) begin
               state_d    = BUSY_I;
               mem_req_d  = 1'b1;
               mem_wr_d   = 1'b0;
               mem_addr_d = bus.i_addr;
               starve_d   = 4'd0;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY_I, BUSY_D: begin
            if (bus.mem_done && mem_req_q) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               mem_wr_d  = 1'b0;
               i_done_d  = (state_q == BUSY_I);
               d_done_d  = (state_q == BUSY_D);
               // Writes leave the last read value visible.
               if (!mem_wr_q) begin
                  rdata_d = bus.mem_rdata;
               end else begin
                  rdata_d = rdata_q;
               end
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            mem_wr_d  = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         starve_q    <= 4'd0;
         mem_req_q   <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         i_done_q    <= 1'b0;
         d_done_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         mem_req_q   <= mem_req_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         i_done_q    <= i_done_d;
         d_done_q    <= d_done_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.i_done    = i_done_q;
   assign bus.d_done    = d_done_q;
   assign bus.rdata     = rdata_q;
   assign bus.busy      = busy_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: inputs driven and outputs sampled on the falling edge.
module tb_mem_arb;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   mem_arb_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   mem_arb #(.ADDR_W(16), .DATA_W(16), .STARVE_LIM(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One contended grant with a single-cycle memory: fetch at 0x0100, data at 0x0200.
   task automatic grant_step(input logic exp_fetch, input string tag);
      @(negedge clk);
      chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd1);
      chk({tag, "_mem_addr"}, 32'(bus.mem_addr), exp_fetch ? 32'h0100 : 32'h0200);
      chk({tag, "_mem_wr"}, 32'(bus.mem_wr), 32'd0);
      bus.mem_done  = 1'b1;
      bus.mem_rdata = exp_fetch ? 16'h1111 : 16'h2222;
      @(negedge clk);
      chk({tag, "_i_done"}, 32'(bus.i_done), 32'(exp_fetch));
      chk({tag, "_d_done"}, 32'(bus.d_done), 32'(!exp_fetch));
      chk({tag, "_rdata"}, 32'(bus.rdata), exp_fetch ? 32'h1111 : 32'h2222);
      bus.mem_done = 1'b0;
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.i_req     = 1'b0;
      bus.i_addr    = 16'h0000;
      bus.d_req     = 1'b0;
      bus.d_wr      = 1'b0;
      bus.d_addr    = 16'h0000;
      bus.d_wdata   = 16'h0000;
      bus.mem_done  = 1'b0;
      bus.mem_rdata = 16'h0000;

      // Reset state, then idle with no requests.
      @(negedge clk);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_rdata", 32'(bus.rdata), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("idle_mem_req", 32'(bus.mem_req), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);

      // Single fetch, memory latency 3.
      bus.i_req  = 1'b1;
      bus.i_addr = 16'h0040;
      @(negedge clk);
      chk("f_mem_req1", 32'(bus.mem_req), 32'd1);
      chk("f_mem_wr", 32'(bus.mem_wr), 32'd0);
      chk("f_mem_addr", 32'(bus.mem_addr), 32'h0040);
      chk("f_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      chk("f_mem_req2", 32'(bus.mem_req), 32'd1);
      chk("f_i_done_early", 32'(bus.i_done), 32'd0);
      @(negedge clk);
      chk("f_mem_req3", 32'(bus.mem_req), 32'd1);
      bus.mem_done  = 1'b1;
      bus.mem_rdata = 16'hBEEF;
      @(negedge clk);
      chk("f_i_done", 32'(bus.i_done), 32'd1);
      chk("f_rdata", 32'(bus.rdata), 32'hBEEF);
      chk("f_mem_req_low", 32'(bus.mem_req), 32'd0);
      chk("f_busy_low", 32'(bus.busy), 32'd0);
      bus.i_req    = 1'b0;
      bus.mem_done = 1'b0;
      @(negedge clk);
      chk("f_i_done_pulse", 32'(bus.i_done), 32'd0);
      chk("f_rdata_hold", 32'(bus.rdata), 32'hBEEF);

      // Data write, latency 2, with inputs changing mid-transaction.
      bus.d_req   = 1'b1;
      bus.d_wr    = 1'b1;
      bus.d_addr  = 16'h1000;
      bus.d_wdata = 16'h1234;
      @(negedge clk);
      chk("w_mem_wr", 32'(bus.mem_wr), 32'd1);
      chk("w_mem_addr", 32'(bus.mem_addr), 32'h1000);
      chk("w_mem_wdata", 32'(bus.mem_wdata), 32'h1234);
      bus.d_addr  = 16'hFFFF;
      bus.d_wdata = 16'h5555;
      @(negedge clk);
      chk("w_addr_stable", 32'(bus.mem_addr), 32'h1000);
      chk("w_wdata_stable", 32'(bus.mem_wdata), 32'h1234);
      bus.mem_done  = 1'b1;
      bus.mem_rdata = 16'hAAAA;
      @(negedge clk);
      chk("w_d_done", 32'(bus.d_done), 32'd1);
      chk("w_rdata_kept", 32'(bus.rdata), 32'hBEEF);
      chk("w_mem_wr_clr", 32'(bus.mem_wr), 32'd0);
      bus.d_req    = 1'b0;
      bus.d_wr     = 1'b0;
      bus.mem_done = 1'b0;
      @(negedge clk);
      chk("w_d_done_pulse", 32'(bus.d_done), 32'd0);

      // Stray mem_done while idle is ignored.
      bus.mem_done  = 1'b1;
      bus.mem_rdata = 16'h9999;
      @(negedge clk);
      bus.mem_done = 1'b0;
      chk("stray_i_done", 32'(bus.i_done), 32'd0);
      chk("stray_d_done", 32'(bus.d_done), 32'd0);
      chk("stray_rdata", 32'(bus.rdata), 32'hBEEF);
      chk("stray_mem_req", 32'(bus.mem_req), 32'd0);

      // Contention: D,D,D,D,I,D,D,D,D,I.
      bus.i_addr = 16'h0100;
      bus.d_addr = 16'h0200;
      bus.i_req  = 1'b1;
      bus.d_req  = 1'b1;
      for (int k = 0; k < 10; k++) begin
         grant_step((k == 4) || (k == 9), $sformatf("starve%0d", k));
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      @(negedge clk);

      // Data read abandoned one cycle after grant; a fetch follows.
      bus.d_req  = 1'b1;
      bus.d_addr = 16'h0300;
      @(negedge clk);
      chk("ab_mem_req", 32'(bus.mem_req), 32'd1);
      chk("ab_mem_addr", 32'(bus.mem_addr), 32'h0300);
      @(negedge clk);
      bus.d_req     = 1'b0;
      bus.i_req     = 1'b1;
      bus.i_addr    = 16'h0400;
      bus.mem_done  = 1'b1;
      bus.mem_rdata = 16'h5A5A;
      @(negedge clk);
      chk("ab_d_done", 32'(bus.d_done), 32'd1);
      chk("ab_rdata", 32'(bus.rdata), 32'h5A5A);
      bus.mem_done = 1'b0;
      @(negedge clk);
      chk("ab_d_done_once", 32'(bus.d_done), 32'd0);
      chk("ab_next_addr", 32'(bus.mem_addr), 32'h0400);
      chk("ab_next_req", 32'(bus.mem_req), 32'd1);
      bus.mem_done  = 1'b1;
      bus.mem_rdata = 16'h0F0F;
      @(negedge clk);
      chk("ab_i_done", 32'(bus.i_done), 32'd1);
      bus.i_req    = 1'b0;
      bus.mem_done = 1'b0;
      @(negedge clk);

      // Reset during a data transaction with mem_done pending.
      bus.i_addr = 16'h0100;
      bus.d_addr = 16'h0200;
      bus.i_req  = 1'b1;
      bus.d_req  = 1'b1;
      grant_step(1'b0, "pre0");
      grant_step(1'b0, "pre1");
      @(negedge clk);
      chk("mid_mem_req", 32'(bus.mem_req), 32'd1);
      bus.mem_done  = 1'b1;
      bus.mem_rdata = 16'h7777;
      #2;
      rst = 1'b1;
      #1;
      chk("async_mem_req", 32'(bus.mem_req), 32'd0);
      chk("async_busy", 32'(bus.busy), 32'd0);
      chk("async_rdata", 32'(bus.rdata), 32'd0);
      @(negedge clk);
      chk("rst_no_d_done", 32'(bus.d_done), 32'd0);
      chk("rst_mem_req_held", 32'(bus.mem_req), 32'd0);
      bus.mem_done = 1'b0;
      rst          = 1'b0;
      // A cleared starvation count lets four data grants through before fetch.
      for (int k = 0; k < 5; k++) begin
         grant_step(k == 4, $sformatf("post%0d", k));
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port arbiter sharing the single-ported, variable-latency main memory between instruction fetch (read-only) and the data-memory stage (read/write). It latches the winning request, holds it on the memory bus until the memory signals completion, and returns a one-cycle done pulse plus read data to the winner. Data requests have priority, bounded by a starvation counter that guarantees fetch forward progress.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `STARVE_LIM`, 4, consecutive data grants allowed while fetch waits (legal 1..15)

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset; one clock, reset asynchronous active-high
- `i_req`  in  1  fetch read request, level, held until `i_done`
- `i_addr`  in  ADDR_W  fetch address
- `d_req`  in  1  data request, level, held until `d_done`
- `d_wr`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `i_done`  out  1  one-cycle pulse, fetch transaction complete
- `d_done`  out  1  one-cycle pulse, data transaction complete
- `rdata`  out  DATA_W  read data, registered, valid from the done cycle until the next read completes
- `busy`  out  1  high in BUSY_I/BUSY_D
- `mem_req`  out  1  registered request to memory
- `mem_wr`  out  1  registered write enable
- `mem_addr`  out  ADDR_W  registered address
- `mem_wdata`  out  DATA_W  registered write data
- `mem_done`  in  1  memory completion, sampled only while `mem_req` high
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_done`

## Operation
- States: IDLE, BUSY_I, BUSY_D. Reset → IDLE.
- IDLE: sample requests at clock edge.
  - Only `d_req` → BUSY_D. Only `i_req` → BUSY_I. Neither → stay.
  - Both: BUSY_I if `starve_cnt == STARVE_LIM`, else BUSY_D.
  - On grant, latch addr/wr/wdata into `mem_*`; set `mem_req`. Fetch grants force `mem_wr=0`.
- `starve_cnt` (4 bits): data grant with `i_req` high → +1; data grant with `i_req` low → 0; fetch grant → 0. Never exceeds STARVE_LIM.
- BUSY_x: `mem_*` held stable. Edge with `mem_done=1` → IDLE, clear `mem_req`/`mem_wr`, pulse `x_done` for the next cycle; on reads load `rdata` from `mem_rdata`, writes leave `rdata` unchanged.
- Request inputs are ignored in BUSY states. Requester dropping `req` mid-transaction does not abort; transaction completes and `done` still pulses.
- A `req` still high at the edge ending the done cycle is a new request (done cycle is an IDLE cycle).
- `mem_done` while `mem_req` low: ignored.
- Reset mid-transaction: asynchronous return to IDLE; in-flight transaction discarded, no done pulse.

## Timing
- Reset values: `mem_req`, `mem_wr`, `i_done`, `d_done`, `busy` = 0; `mem_addr`, `mem_wdata`, `rdata` = 0; `starve_cnt` = 0.
- Request sampled at edge T → `mem_req` high from T+1.
- `mem_done` sampled at edge E → `x_done` and `rdata` valid E+1 to E+2; `mem_req` low same cycle.
- Memory latency L (cycles `mem_req` high incl. done cycle) → requester latency L+1 from request to done; back-to-back throughput one transaction per L+1 cycles.
- All outputs registered; no combinational input→output path.

## Test plan
- Reset: assert `rst` mid-cycle → all outputs 0 immediately, no clock needed; deassert, no requests → stays IDLE, `mem_req=0`.
- Single fetch: `i_req`, `i_addr=0x0040`, memory L=3 returning 0xBEEF → `mem_req` 3 cycles, `mem_wr=0`, `i_done` pulse 4 cycles after request, `rdata=0xBEEF`.
- Data write: `d_wr=1`, `d_addr=0x1000`, `d_wdata=0x1234` → `mem_wr=1`, address/data stable until `mem_done`, `d_done` pulse, `rdata` unchanged.
- Starvation: `i_req` and `d_req` continuously high, STARVE_LIM=4 → grant order D,D,D,D,I,D,D,D,D,I.
- Abandoned request: drop `d_req` one cycle after grant → transaction completes, `d_done` still pulses once, next grant follows normal arbitration.
- Reset mid-transaction: `rst` in BUSY_D with `mem_done` pending → `mem_req` drops asynchronously, no `d_done`, `starve_cnt=0`.
